cra32_selfcheck: RTL and testbench

Self-checking, registered 32-bit ripple-carry adder. It captures an operand pair and a carry-in, then adds them in a structural ripple-carry chain of full adders. The result is compared against a behavioural reference sum, and the block keeps running vector and error counts. It sits between a stimulus source and a logging/monitor stage, and supplies the adder result, carry-out and pass/fail status every cycle.

---
 rtl/cra32_selfcheck.sv | 179 +++++++++++++++++
 tb/tb_cra32_selfcheck.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cra32_selfcheck.sv
// cra32_selfcheck: registered N-bit ripple-carry adder with a built-in
// behavioural reference check and saturating vector/error counters.
//
// Interface semantics: in_valid qualifies a/b/cin/inj_fault on the rising
// edge where it is high. There is no backpressure, so every qualified vector
// is accepted. out_valid is high for exactly one cycle per accepted vector,
// one edge after capture. While out_valid is high, s/cout/mismatch describe
// that vector. While out_valid is low, s/cout hold their last values and
// mismatch is 0.

// One full-adder cell of the ripple chain.
module cra32_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    // Sum and carry, built from propagate/generate terms of a single bit.
    always_comb begin
        p   = a_i ^ b_i;
        s_o = p ^ c_i;
        c_o = (a_i & b_i) | (c_i & p);
    end
endmodule

module cra32_selfcheck #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             cin,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             inj_fault,
    output logic [N-1:0]     s,
    output logic             cout,
    output logic             out_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]     BIT0    = {{(N-1){1'b0}}, 1'b1};

    // Stage-0 operand registers.
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         cin_q, cin_d;
    logic         fault_q, fault_d;
    logic         v0_q, v0_d;

    // Stage-1 result registers and counters.
    logic [N-1:0]     s_q, s_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;

    // Ripple chain signals.
    logic [N:0]   c;
    logic [N-1:0] sum_raw;
    logic [N-1:0] s_rca;
    logic         cout_rca;

    // Reference result.
    logic [N:0]   ref_sum;
    logic         diff;

    // Stage-0 capture: load operands only on a qualified edge, otherwise hold.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        fault_d = fault_q;
        v0_d    = in_valid;
        if (in_valid) begin
            a_d     = a;
            b_d     = b;
            cin_d   = cin;
            fault_d = inj_fault;
        end
    end

    // Stage-0 register bank with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            fault_q <= 1'b0;
            v0_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            fault_q <= fault_d;
            v0_q    <= v0_d;
        end
    end

    assign c[0] = cin_q;

    // Structural ripple chain: one full-adder cell per bit, carry in from below.
    for (genvar i = 0; i < N; i++) begin : g_fa
        cra32_fa u_fa (
            .a_i (a_q[i]),
            .b_i (b_q[i]),
            .c_i (c[i]),
            .s_o (sum_raw[i]),
            .c_o (c[i+1])
        );
    end

    // Fault injection flips only bit 0, so the reference must always disagree.
    always_comb begin
        s_rca    = sum_raw ^ (fault_q ? BIT0 : '0);
        cout_rca = c[N];
    end

    // Behavioural reference at N+1 bits and the compare against the chain.
    always_comb begin
        ref_sum = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
        diff    = ({cout_rca, s_rca} != ref_sum);
    end

    // Stage-1 next state: results and counters advance only for a valid vector.
    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        out_valid_d = v0_q;
        mismatch_d  = 1'b0;
        vec_d       = vec_q;
        err_d       = err_q;
        if (v0_q) begin
            s_d        = s_rca;
            cout_d     = cout_rca;
            mismatch_d = diff;
            if (vec_q != CNT_MAX) begin
                vec_d = vec_q + CNT_ONE;
            end
            if (diff && (err_q != CNT_MAX)) begin
                err_d = err_q + CNT_ONE;
            end
        end
    end

    // Stage-1 register bank with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            vec_q       <= '0;
            err_q       <= '0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            mismatch_q  <= mismatch_d;
            vec_q       <= vec_d;
            err_q       <= err_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;
    assign mismatch  = mismatch_q;
    assign vec_count = vec_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_cra32_selfcheck.sv
// Bench for cra32_selfcheck: behavioural model plus directed vectors.
module tb_cra32_selfcheck;
  localparam int N = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          cin;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          inj_fault;
  logic [N-1:0]  s;
  logic          cout;
  logic          out_valid;
  logic          mismatch;
  logic [15:0]   vec_count;
  logic [15:0]   err_count;

  logic          in_valid_s;
  logic          inj_s;
  logic [N-1:0]  s_s;
  logic          cout_s;
  logic          out_valid_s;
  logic          mismatch_s;
  logic [3:0]    vec_count_s;
  logic [3:0]    err_count_s;

  int checks;
  int failures;
  int n_acc;

  // model state
  logic [N+1:0]  exp_q[$];
  logic [N-1:0]  m_s;
  logic          m_cout;
  logic          m_valid;
  logic          m_mis;
  int            m_vec;
  int            m_err;

  cra32_selfcheck #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cin(cin), .a(a), .b(b),
    .inj_fault(inj_fault), .s(s), .cout(cout), .out_valid(out_valid),
    .mismatch(mismatch), .vec_count(vec_count), .err_count(err_count)
  );

  cra32_selfcheck #(.N(N), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .cin(cin), .a(a), .b(b),
    .inj_fault(inj_s), .s(s_s), .cout(cout_s), .out_valid(out_valid_s),
    .mismatch(mismatch_s), .vec_count(vec_count_s), .err_count(err_count_s)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted vector's true sum, with bit 0 flipped when a fault is
  // injected, appears one edge later; a flipped bit always disagrees with a+b+cin.
  initial begin
    logic [N:0] sum;
    logic [N-1:0] sv;
    logic [N+1:0] e;
    m_s = '0; m_cout = 0; m_valid = 0; m_mis = 0; m_vec = 0; m_err = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_s = '0; m_cout = 0; m_valid = 0; m_mis = 0; m_vec = 0; m_err = 0;
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          m_valid = 1'b1;
          m_s = e[N-1:0];
          m_cout = e[N];
          m_mis = e[N+1];
          if (m_vec < 65535) m_vec++;
          if (m_mis && m_err < 65535) m_err++;
        end else begin
          m_valid = 1'b0;
          m_mis = 1'b0;
        end
        if (in_valid === 1'b1) begin
          sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
          sv = sum[N-1:0];
          sv[0] = sv[0] ^ inj_fault;
          exp_q.push_back({inj_fault, sum[N], sv});
        end
      end
    end
  end

  // Compare process: every falling edge, outputs against the model.
  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      check("cyc_out_valid", out_valid, m_valid);
      check("cyc_s", s, m_s);
      check("cyc_cout", cout, m_cout);
      check("cyc_mismatch", mismatch, m_mis);
      check("cyc_vec_count", vec_count, m_vec);
      check("cyc_err_count", err_count, m_err);
    end
  end

  // driver: one vector, result visible on return
  task automatic apply(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc, input logic tf);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; inj_fault = tf; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; inj_fault = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; n_acc = 0;
    rst_n = 1'b0; in_valid = 0; cin = 0; a = '0; b = '0; inj_fault = 0;
    in_valid_s = 0; inj_s = 0;
    repeat (3) @(negedge clk);
    check("rst_s", s, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_vec", vec_count, 0);
    rst_n = 1'b1;

    // basic add
    apply(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
    check("basic_s", s, 32'h0000_0009);
    check("basic_cout", cout, 0);
    check("basic_mis", mismatch, 0);
    check("basic_vec", vec_count, 1);

    // full ripple
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    check("ripple1_s", s, 32'h0000_0000);
    check("ripple1_cout", cout, 1);
    check("ripple1_mis", mismatch, 0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("ripple2_s", s, 32'hFFFF_FFFF);
    check("ripple2_cout", cout, 1);

    // fault detection
    apply(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    check("fault_s", s, 32'h2345_6788);
    check("fault_mis", mismatch, 1);
    check("fault_err", err_count, 1);
    apply(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    check("nofault_s", s, 32'h2345_6789);
    check("nofault_mis", mismatch, 0);
    check("nofault_err", err_count, 1);
    check("nofault_vec", vec_count, 5);

    // reset mid-stream with a vector in flight and out_valid high
    @(negedge clk);
    a = 32'd1; b = 32'd2; cin = 0; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s", s, 0);
    check("midrst_mis", mismatch, 0);
    check("midrst_vec", vec_count, 0);
    check("midrst_err", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_first_edge", out_valid, 0);
    @(negedge clk);
    check("post_rst_second_edge", out_valid, 1);
    check("post_rst_s", s, 32'd3);
    check("post_rst_vec", vec_count, 1);
    in_valid = 1'b0;
    @(negedge clk);

    // random back-to-back with bubbles, counts from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); inj_fault = 1'b0;
      if (in_valid) n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rand_vec_total", vec_count, n_acc);
    check("rand_err_total", err_count, 0);

    // saturation on the narrow-counter instance
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      in_valid_s = 1'b1; inj_s = 1'b1;
      if (i == 15) begin
        check("sat_vec_at14", vec_count_s, 14);
      end
    end
    @(negedge clk);
    in_valid_s = 1'b0; inj_s = 1'b0;
    @(negedge clk);
    check("sat_vec", vec_count_s, 15);
    check("sat_err", err_count_s, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
